// File: rtl/axi_read_master.sv
// AXI4 single-burst read master: accepts one read command, issues one INCR
// AR, forwards R beats straight onto an AXI-Stream output with tlast taken
// from the local beat count, and reports response/ID/length/size errors on
// a one-cycle done pulse.
module axi_read_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int ARID_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  done,
  output logic [2:0]            err
);

  localparam logic [ID_WIDTH-1:0] LP_ARID     = ID_WIDTH'(ARID_VALUE);
  localparam logic [2:0]          LP_MAX_SIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic                  r_arvalid;
  logic                  w_arvalid_nxt;
  logic [8:0]            r_cnt;
  logic [8:0]            w_cnt_nxt;
  logic [2:0]            r_err;
  logic [2:0]            w_err_nxt;
  // Set once the counted final beat arrived without rlast: remaining beats
  // of the slave's burst are swallowed until rlast shows up.
  logic                  r_drain;
  logic                  w_drain_nxt;
  logic                  w_cmd_acc;
  logic                  w_beat;
  logic                  w_last_cnt;

  // Constant and latched AR channel fields.
  assign m_axi_arid    = LP_ARID;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign done          = (r_state == S_DONE);
  assign err           = r_err;
  assign w_last_cnt    = (r_cnt == {1'b0, r_arlen});

  // Next-state, handshake outputs and beat bookkeeping.
  always_comb begin
    w_state_nxt   = r_state;
    w_arvalid_nxt = r_arvalid;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    w_drain_nxt   = r_drain;
    w_cmd_acc     = 1'b0;
    w_beat        = 1'b0;
    cmd_ready     = 1'b0;
    m_axi_rready  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = rst;
        if (cmd_valid && rst) begin
          w_cmd_acc   = 1'b1;
          w_cnt_nxt   = 9'd0;
          w_drain_nxt = 1'b0;
          // An unsupported beat size never reaches the bus.
          if (cmd_size > LP_MAX_SIZE) begin
            w_err_nxt   = 3'b100;
            w_state_nxt = S_DONE;
          end else begin
            w_err_nxt     = 3'b000;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        m_axi_rready  = rst & (r_drain | m_axis_tready);
        m_axis_tvalid = rst & m_axi_rvalid & ~r_drain;
        m_axis_tlast  = w_last_cnt & ~r_drain;
        w_beat        = m_axi_rvalid & m_axi_rready;
        if (w_beat) begin
          if (m_axi_rresp != 2'b00) w_err_nxt[0] = 1'b1;
          if (m_axi_rid != LP_ARID) w_err_nxt[1] = 1'b1;
          if (r_drain) begin
            if (m_axi_rlast) w_state_nxt = S_DONE;
          end else if (!w_last_cnt) begin
            w_cnt_nxt = r_cnt + 9'd1;
            if (m_axi_rlast) begin
              w_err_nxt[2] = 1'b1;
              w_state_nxt  = S_DONE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
            if (m_axi_rlast) begin
              w_state_nxt = S_DONE;
            end else begin
              w_err_nxt[2] = 1'b1;
              w_drain_nxt  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters, flags and latched command fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_cnt     <= 9'd0;
      r_err     <= 3'b000;
      r_drain   <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arsize  <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
      r_drain   <= w_drain_nxt;
      if (w_cmd_acc) begin
        r_araddr <= cmd_addr;
        r_arlen  <= cmd_len;
        r_arsize <= cmd_size;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: a RAM-backed AXI slave driven from one initial
// block, with a queue scoreboard of expected stream words and expected error
// flags derived from the fault injected into each burst.
module tb_axi_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [7:0]  m_axi_arid;
  logic [15:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [7:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        done;
  logic [2:0]  err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ram [64];

  always #5 clk = ~clk;

  axi_read_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete command: size check, AR phase, R/stream phase, done pulse.
  // rlast_beat is the 0-based index of the slave's rlast beat; resp_bad and
  // id_bad are beat indices carrying a bad response / wrong ID (-1 = none);
  // rst_after >= 0 pulls reset once that many beats have transferred.
  task automatic burst(input logic [15:0] addr, input int len, input int size,
                       input int ar_delay, input int tmode, input int resp_bad,
                       input int id_bad, input int rlast_beat, input int rst_after);
    logic [31:0] expq[$];
    logic [2:0]  exp_err;
    int nbeats, beat, sbeats, cyc;
    bit xfer, tr;
    nbeats  = rlast_beat + 1;
    exp_err = {rlast_beat != len, id_bad >= 0 && id_bad < nbeats,
               resp_bad >= 0 && resp_bad < nbeats};
    for (int i = 0; i <= len && i < nbeats; i++) expq.push_back(ram[(int'(addr) + i) % 64]);

    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_size = 3'(size);
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;

    if (size > 2) begin
      #1;
      chk("badsize_no_ar", 64'(m_axi_arvalid), 64'd0);
      chk("badsize_done", 64'(done), 64'd1);
      chk("badsize_err", 64'(err), 64'b100);
      @(posedge clk); @(negedge clk);
      #1 chk("badsize_idle", 64'(cmd_ready), 64'd1);
      chk("badsize_done_low", 64'(done), 64'd0);
      return;
    end

    for (int k = 0; k <= ar_delay; k++) begin
      m_axi_arready = (k == ar_delay);
      #1;
      chk("arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("araddr", 64'(m_axi_araddr), 64'(addr));
      chk("arlen", 64'(m_axi_arlen), 64'(len));
      chk("arsize", 64'(m_axi_arsize), 64'(size));
      chk("ar_const", 64'({m_axi_arburst, m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot}),
          64'({2'b01, 8'd0, 1'b0, 4'd0, 3'd0}));
      @(posedge clk); @(negedge clk);
    end
    m_axi_arready = 1'b0;
    #1 chk("arvalid_drop", 64'(m_axi_arvalid), 64'd0);

    beat = 0; sbeats = 0; cyc = 0;
    while (beat < nbeats && cyc < 400) begin
      if (beat == rst_after) begin
        m_axi_rvalid = 1'b0; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_outputs", 64'({m_axi_arvalid, done, err, m_axis_tvalid}), 64'd0);
        chk("rst_ar_fields", 64'({m_axi_araddr, m_axi_arlen, m_axi_arsize}), 64'd0);
        rst = 1'b1;
        #1 chk("rst_release_ready", 64'(cmd_ready), 64'd1);
        return;
      end
      m_axi_rvalid = ($urandom_range(0, 3) != 0);
      m_axi_rdata  = ram[(int'(addr) + beat) % 64];
      m_axi_rresp  = (beat == resp_bad) ? 2'b10 : 2'b00;
      m_axi_rid    = (beat == id_bad) ? 8'h05 : 8'h00;
      m_axi_rlast  = (beat == rlast_beat);
      tr = (tmode == 0) ? 1'b1 : (tmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      m_axis_tready = tr;
      #1;
      chk("rready", 64'(m_axi_rready), 64'((beat > len) ? 1'b1 : tr));
      chk("tvalid", 64'(m_axis_tvalid), 64'(m_axi_rvalid && beat <= len));
      if (m_axis_tvalid && m_axis_tready) begin
        chk("tdata", 64'(m_axis_tdata), 64'(expq.size() > 0 ? expq.pop_front() : 32'hDEAD_BEEF));
        chk("tlast", 64'(m_axis_tlast), 64'(sbeats == len));
        sbeats++;
      end
      xfer = m_axi_rvalid && m_axi_rready;
      @(posedge clk); @(negedge clk);
      if (xfer) beat++;
      cyc++;
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    if (cyc >= 400) chk("data_timeout", 64'd1, 64'd0);
    #1;
    chk("beats", 64'(sbeats), 64'((len + 1 < nbeats) ? len + 1 : nbeats));
    chk("done", 64'(done), 64'd1);
    chk("err", 64'(err), 64'(exp_err));
    chk("done_ready_low", 64'({cmd_ready, m_axi_rready, m_axis_tvalid}), 64'd0);
    @(posedge clk); @(negedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    chk("err_hold", 64'(err), 64'(exp_err));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[4] = 32'h1234_5678;
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_rready", 64'(m_axi_rready), 64'd0);
    chk("reset_outputs", 64'({m_axi_arvalid, done, err}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    burst(16'd4,  3, 0, 0,  0, -1, -1, 3, -1);  // basic 4-beat burst
    burst(16'd4,  3, 0, 0,  1, -1, -1, 3, -1);  // tready toggling
    burst(16'd8,  5, 2, 10, 2, -1, -1, 5, -1);  // arready withheld 10 cycles
    burst(16'd12, 3, 2, 1,  0,  1,  2, 3, -1);  // SLVERR then wrong ID
    burst(16'd4,  3, 0, 0,  0, -1, -1, 0, -1);  // early rlast
    burst(16'd0,  3, 3, 0,  0, -1, -1, 3, -1);  // unsupported size
    burst(16'd20, 1, 1, 0,  2, -1, -1, 3, -1);  // late rlast, drain
    burst(16'd0,  0, 2, 2,  2, -1, -1, 0, -1);  // single beat
    burst(16'd4,  7, 2, 0,  0, -1, -1, 7,  2);  // reset mid-burst
    burst(16'd4,  3, 0, 0,  0, -1, -1, 3, -1);  // normal after reset
    for (int t = 0; t < 6; t++) begin
      int l;
      l = $urandom_range(0, 7);
      burst(16'($urandom_range(0, 63)), l, $urandom_range(0, 2), $urandom_range(0, 3),
            2, -1, -1, l, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, R data and stream width; ADDR_WIDTH, default 16, address width; STRB_WIDTH, default DATA_WIDTH/8, byte lanes; ID_WIDTH, default 8, AXI ID width; ARID_VALUE, default 0, constant ARID driven on every burst.
REQ-002 SHALL have one clock and a synchronous, active-low reset; ports named clk and rst as in the codebase.
REQ-003 SHALL have these ports:
  clk  in  1  clock; all logic on rising edge
  rst  in  1  synchronous active-low reset
  cmd_valid  in  1  read command valid
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_addr  in  ADDR_WIDTH  burst start address
  cmd_len  in  8  beats minus one (AXI ARLEN)
  cmd_size  in  3  bytes per beat log2 (AXI ARSIZE)
  m_axi_arid  out  ID_WIDTH  = ARID_VALUE
  m_axi_araddr  out  ADDR_WIDTH  latched cmd_addr
  m_axi_arlen  out  8  latched cmd_len
  m_axi_arsize  out  3  latched cmd_size
  m_axi_arburst  out  2  constant 2'b01 (INCR)
  m_axi_arlock / arcache / arprot  out  1 / 4 / 3  constant 0
  m_axi_arvalid  out  1  address valid
  m_axi_arready  in  1  address accepted
  m_axi_rid  in  ID_WIDTH  read ID
  m_axi_rdata  in  DATA_WIDTH  read data
  m_axi_rresp  in  2  read response
  m_axi_rlast  in  1  last beat
  m_axi_rvalid  in  1  read beat valid
  m_axi_rready  out  1  read beat accepted
  m_axis_tdata  out  DATA_WIDTH  forwarded beat data
  m_axis_tlast  out  1  final counted beat of burst
  m_axis_tvalid  out  1  stream valid
  m_axis_tready  in  1  stream backpressure
  done  out  1  one-cycle burst-complete pulse
  err  out  3  status at done: bit0 resp, bit1 id, bit2 last/size

Function
REQ-004 SHALL implement states IDLE, ADDR, DATA, DONE; one burst outstanding at a time.
REQ-005 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches addr/len/size, clears beat counter and error flags, enters ADDR next cycle.
REQ-006 If latched cmd_size exceeds log2(STRB_WIDTH), the block SHALL skip ADDR/DATA, go directly to DONE with err[2]=1, issuing no AR.
REQ-007 ADDR: m_axi_arvalid=1 (registered) with stable AR fields until m_axi_arready sampled high; that cycle transitions to DATA; arvalid deasserts the following cycle.
REQ-008 DATA: m_axi_rready = m_axis_tready; m_axis_tvalid = m_axi_rvalid; m_axis_tdata = m_axi_rdata (combinational pass-through, zero latency).
REQ-009 A beat SHALL transfer only when m_axi_rvalid & m_axi_rready; 9-bit beat counter increments per beat.
REQ-010 m_axis_tlast SHALL be 1 when counter equals latched len, independent of m_axi_rlast.
REQ-011 Any beat with rresp != 2'b00 SHALL set sticky err[0]; rid != ARID_VALUE SHALL set sticky err[1]; data still forwarded.
REQ-012 rlast=1 on beat with counter < len SHALL set err[2] and end the burst (DATA->DONE).
REQ-013 Beat with counter == len and rlast=0 SHALL set err[2]; block SHALL keep draining (rready=1, tvalid=0, beats discarded) until rlast beat, then DONE.
REQ-014 Beat with counter == len and rlast=1 SHALL enter DONE next cycle.
REQ-015 DONE: lasts exactly one cycle; done=1; err holds final flags; cmd_ready=0; then IDLE.
REQ-016 Outside DATA, m_axi_rready=0 and m_axis_tvalid=0; err SHALL hold its value until the next command is accepted.

Reset
REQ-017 rst=0 at a rising edge SHALL force IDLE, arvalid=0, done=0, err=0, counter=0, latched AR fields=0 regardless of state, including mid-burst; outstanding R beats after reset are not the block's responsibility.
REQ-018 While rst=0, cmd_ready=0 and m_axi_rready=0.

Verification
REQ-019 Cmd addr=4, len=3, size=0 to RAM holding 0x12345678 at word 4 -> one AR (araddr=4, arlen=3, arburst=01), 4 stream beats, tlast on 4th only, done pulse, err=0.
REQ-020 Same burst with m_axis_tready toggling 1/0 each cycle -> no beat lost or duplicated, rready tracks tready, 4 beats, err=0.
REQ-021 arready withheld 10 cycles -> arvalid held high with stable fields 10 cycles, drops cycle after handshake.
REQ-022 Slave responds rresp=2'b10 on beat 2 of len=3, then rid=0x5 on beat 3 -> all beats forwarded, done with err=3'b011.
REQ-023 Slave asserts rlast on beat 1 (len=3) -> done next cycle, err=3'b100; cmd_size=3 with DATA_WIDTH=32 -> no AR, done, err=3'b100.
REQ-024 rst=0 during DATA after 2 beats -> next cycle IDLE, all outputs at reset values, new command accepted normally.
